dp_cmd_scheduler: RTL and testbench
===================================

Name: dp_cmd_scheduler

Overview:
- Shares one x/y/s datapath between two requesters. Each requester issues a command: 1 = enumerate, 2 = count, 3 = update.
- Arbitrates round-robin, latches the winner's operand, and drives the datapath control word cycle by cycle until the command completes.
- Sits between the requester front-ends and the datapath; it is the sole driver of all datapath control inputs.

Parameters:
ENUM_LEN, 6, enumerate length in cycles (range 2..15)
COUNT_LEN, 8, count length in cycles (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req0  in  1  requester 0 request, level
cmd0  in  2  requester 0 command
x0  in  8  requester 0 operand
req1  in  1  requester 1 request, level
cmd1  in  2  requester 1 command
x1  in  8  requester 1 operand
s_is_zero  in  1  datapath s == 0 flag
gnt0, gnt1  out  1  grant to the respective requester
done0, done1  out  1  one-cycle completion pulse to the respective requester
busy  out  1  a command is in progress
dp_x  out  8  operand driven to the datapath
regime  out  2  current command, 0 when idle
active  out  1  enumerate-active indicator
y_en, y_upd, s_en, s_sub, s_zero  out  1  datapath controls
y_select_next, s_step  out  2  datapath controls

Behaviour:
- Reset (rst async, active-high; clock clk):
  - All outputs 0; state IDLE; counter 0; last_owner = 1, so requester 0 wins first.
  - A reset mid-command aborts it with no done pulse.
- All outputs are registered or decoded from registered state. There are no combinational paths from req/cmd/x to outputs.
- Arbitration, in IDLE only:
  - If exactly one req is high, that requester wins.
  - If both are high, the requester that is not last_owner wins.
  - On the clock edge that wins, latch owner, cmd and x. The next state is the first state of the command.
- Grant and operand:
  - gnt_owner is high from the first command cycle through DONE inclusive.
  - dp_x holds the latched operand for the same span and is 0 otherwise.
  - req or cmd changes after the latch edge are ignored; a started command always runs to completion.
- Command states and control word (signals not listed are 0):
  - IDLE: everything 0.
  - UPD_LOAD, 1 cycle: regime=3, y_en=1.
  - UPD_STEP, 1 cycle: regime=3, y_en=1, y_upd=1, y_select_next=1, s_en=1, s_sub=1, s_step=1. Then go to DONE.
  - CNT_RUN: regime=2, s_en=1, s_sub=1, s_step=1.
  - CNT_WRAP: as CNT_RUN, plus y_en=1 and y_select_next=2.
  - ENUM_RUN, ENUM_LEN cycles: regime=1, active=1, s_en=1, s_sub=1, s_step=2. s_zero=1 in the first and last ENUM cycle only.
  - DONE, 1 cycle: regime=0; done_owner=1; busy=1; last_owner is updated to owner; next state is IDLE.
- Count sequencing:
  - Exactly COUNT_LEN cycles in total across CNT_RUN and CNT_WRAP, tracked by a 4-bit counter, then go to DONE.
  - Each count cycle is CNT_WRAP if s_is_zero was high in the previous cycle, otherwise CNT_RUN. The first count cycle is always CNT_RUN.
- cmd = 0: no datapath activity. State goes IDLE → DONE, so gnt and done are high together for 1 cycle.
- busy = 1 in every non-IDLE state.
- Total latency from the latch edge to done: update 3 cycles, count COUNT_LEN+1 cycles, enumerate ENUM_LEN+1 cycles, cmd 0 1 cycle.
- Back-to-back commands: the earliest new grant is 2 cycles after DONE (DONE → IDLE latch → first command state). There is no re-arbitration while busy.
- A requester whose req is still high after DONE is treated as a new request; round-robin applies.

Test Plan:
1. Reset, then req0 with cmd0=3, x0=0x5A for 1 cycle at t:
   - t+1: gnt0=1, y_en=1.
   - t+2: y_upd=1, s_step=1.
   - t+3: done0=1, regime=0.
   - dp_x=0x5A over t+1..t+3; gnt1 stays 0.
2. req0 and req1 both high, cmd=1, x0=0x11, x1=0x22:
   - Requester 0 is served first: 6 cycles with active=1, s_zero=1 in cycles 1 and 6, then done0.
   - Requester 1 is granted 2 cycles later with dp_x=0x22, then done1.
   - With both requests held, the third grant goes to requester 0.
3. cmd0=2 with s_is_zero high only during count cycle 3:
   - Count cycle 4 is CNT_WRAP (y_en=1, y_select_next=2); all other count cycles are CNT_RUN.
   - 8 count cycles total, then done0.
4. cmd1=0 → at t+1: gnt1=1, done1=1, busy=1, every control output 0; at t+2: IDLE.
5. Assert rst during enumerate cycle 3:
   - All outputs 0 immediately, with no done.
   - After release, with both req high, requester 0 wins.
6. req0 drops and cmd0 changes right after the grant → the original command completes unchanged and done0 pulses at its scheduled cycle.

Source files
------------

// File: rtl/dp_cmd_scheduler.sv
// Round-robin scheduler that hands one shared x/y/s datapath to one of two
// requesters and sequences the datapath control word until the command ends.
module dp_cmd_scheduler #(
  parameter int ENUM_LEN  = 6,
  parameter int COUNT_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [1:0] cmd0,
  input  logic [7:0] x0,
  input  logic       req1,
  input  logic [1:0] cmd1,
  input  logic [7:0] x1,
  input  logic       s_is_zero,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       busy,
  output logic [7:0] dp_x,
  output logic [1:0] regime,
  output logic       active,
  output logic       y_en,
  output logic       y_upd,
  output logic       s_en,
  output logic       s_sub,
  output logic       s_zero,
  output logic [1:0] y_select_next,
  output logic [1:0] s_step
);

  typedef enum logic [2:0] {
    IDLE, UPD_LOAD, UPD_STEP, CNT_RUN, CNT_WRAP, ENUM_RUN, DONE
  } state_t;

  localparam logic [3:0] ENUM_LAST  = 4'(ENUM_LEN - 1);
  localparam logic [3:0] COUNT_LAST = 4'(COUNT_LEN - 1);

  state_t     state, state_nxt;
  logic       owner;
  logic       last_owner;
  logic [7:0] x_q;
  logic [3:0] cnt;
  logic       win;
  logic [1:0] win_cmd;
  logic       any_req;

  // Both requesting: the one that did not own the datapath last time wins.
  assign any_req = req0 | req1;
  assign win     = req1 & (~req0 | ~last_owner);
  assign win_cmd = win ? cmd1 : cmd0;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          unique case (win_cmd)
            2'd3:    state_nxt = UPD_LOAD;
            2'd2:    state_nxt = CNT_RUN;
            2'd1:    state_nxt = ENUM_RUN;
            default: state_nxt = DONE;
          endcase
        end
      end
      UPD_LOAD: state_nxt = UPD_STEP;
      UPD_STEP: state_nxt = DONE;
      CNT_RUN, CNT_WRAP: begin
        if (cnt == COUNT_LAST)  state_nxt = DONE;
        else if (s_is_zero)     state_nxt = CNT_WRAP;
        else                    state_nxt = CNT_RUN;
      end
      ENUM_RUN: if (cnt == ENUM_LAST) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      x_q        <= '0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner <= win;
            x_q   <= win ? x1 : x0;
            cnt   <= '0;
          end
        end
        CNT_RUN, CNT_WRAP, ENUM_RUN: cnt <= cnt + 4'd1;
        DONE:    last_owner <= owner;
        default: ;
      endcase
    end
  end

  // Control word is a pure decode of registered state.
  always_comb begin
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    done0         = 1'b0;
    done1         = 1'b0;
    busy          = (state != IDLE);
    dp_x          = '0;
    regime        = 2'd0;
    active        = 1'b0;
    y_en          = 1'b0;
    y_upd         = 1'b0;
    s_en          = 1'b0;
    s_sub         = 1'b0;
    s_zero        = 1'b0;
    y_select_next = 2'd0;
    s_step        = 2'd0;
    if (busy) begin
      gnt0 = ~owner;
      gnt1 = owner;
      dp_x = x_q;
    end
    unique case (state)
      UPD_LOAD: begin
        regime = 2'd3;
        y_en   = 1'b1;
      end
      UPD_STEP: begin
        regime        = 2'd3;
        y_en          = 1'b1;
        y_upd         = 1'b1;
        y_select_next = 2'd1;
        s_en          = 1'b1;
        s_sub         = 1'b1;
        s_step        = 2'd1;
      end
      CNT_RUN, CNT_WRAP: begin
        regime = 2'd2;
        s_en   = 1'b1;
        s_sub  = 1'b1;
        s_step = 2'd1;
        if (state == CNT_WRAP) begin
          y_en          = 1'b1;
          y_select_next = 2'd2;
        end
      end
      ENUM_RUN: begin
        regime = 2'd1;
        active = 1'b1;
        s_en   = 1'b1;
        s_sub  = 1'b1;
        s_step = 2'd2;
        s_zero = (cnt == 4'd0) || (cnt == ENUM_LAST);
      end
      DONE: begin
        done0 = ~owner;
        done1 = owner;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dp_cmd_scheduler.sv
// Directed bench for dp_cmd_scheduler: checks the full control word and dp_x
// cycle by cycle against hand-derived expectations.
module tb_dp_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, s_is_zero;
  logic [1:0] cmd0, cmd1;
  logic [7:0] x0, x1;
  logic       gnt0, gnt1, done0, done1, busy, active;
  logic       y_en, y_upd, s_en, s_sub, s_zero;
  logic [7:0] dp_x;
  logic [1:0] regime, y_select_next, s_step;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int K_IDLE = 0, K_LOAD = 1, K_STEP = 2, K_RUN = 3,
                 K_WRAP = 4, K_ENUM = 5, K_DONE = 6;

  dp_cmd_scheduler #(.ENUM_LEN(6), .COUNT_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .cmd0(cmd0), .x0(x0),
    .req1(req1), .cmd1(cmd1), .x1(x1),
    .s_is_zero(s_is_zero),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .busy(busy), .dp_x(dp_x), .regime(regime), .active(active),
    .y_en(y_en), .y_upd(y_upd), .s_en(s_en), .s_sub(s_sub), .s_zero(s_zero),
    .y_select_next(y_select_next), .s_step(s_step)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {gnt0, gnt1, done0, done1, busy, regime, active, y_en, y_upd,
                s_en, s_sub, s_zero, y_select_next, s_step};

  // Expected control word for one state, written straight from the state table.
  function automatic logic [16:0] ew(input int kind, input bit own, input bit sz);
    logic g0, g1, d0, d1, b, act, ye, yu, se, ss, szo;
    logic [1:0] rg, ysn, st;
    {g0, g1, d0, d1, b, act, ye, yu, se, ss, szo} = '0;
    rg = 2'd0; ysn = 2'd0; st = 2'd0;
    if (kind != K_IDLE) begin
      b  = 1'b1;
      g0 = !own;
      g1 = own;
    end
    case (kind)
      K_LOAD: begin rg = 2'd3; ye = 1'b1; end
      K_STEP: begin rg = 2'd3; ye = 1'b1; yu = 1'b1; ysn = 2'd1;
                    se = 1'b1; ss = 1'b1; st = 2'd1; end
      K_RUN:  begin rg = 2'd2; se = 1'b1; ss = 1'b1; st = 2'd1; end
      K_WRAP: begin rg = 2'd2; se = 1'b1; ss = 1'b1; st = 2'd1;
                    ye = 1'b1; ysn = 2'd2; end
      K_ENUM: begin rg = 2'd1; act = 1'b1; se = 1'b1; ss = 1'b1;
                    st = 2'd2; szo = sz; end
      K_DONE: begin d0 = !own; d1 = own; end
      default: ;
    endcase
    return {g0, g1, d0, d1, b, rg, act, ye, yu, se, ss, szo, ysn, st};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic cw(input string tag, input int kind, input bit own,
                    input bit sz, input logic [7:0] x_exp);
    check({tag, "_ctl"}, 32'(obs), 32'(ew(kind, own, sz)));
    check({tag, "_dpx"}, 32'(dp_x), 32'(x_exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; s_is_zero = 0;
    cmd0 = 0; cmd1 = 0; x0 = 0; x1 = 0;
    step(); step();
    cw("reset", K_IDLE, 0, 0, 8'h00);
    rst = 1'b0;

    // 1: update from requester 0, request held one cycle only
    req0 = 1; cmd0 = 2'd3; x0 = 8'h5A;
    step(); cw("t1_load", K_LOAD, 0, 0, 8'h5A); req0 = 0;
    step(); cw("t1_step", K_STEP, 0, 0, 8'h5A);
    step(); cw("t1_done", K_DONE, 0, 0, 8'h5A);
    step(); cw("t1_idle", K_IDLE, 0, 0, 8'h00);

    // 2: both request enumerate from fresh reset; alternate ownership
    rst = 1'b1; step(); rst = 1'b0;
    req0 = 1; req1 = 1; cmd0 = 2'd1; cmd1 = 2'd1; x0 = 8'h11; x1 = 8'h22;
    for (int i = 1; i <= 6; i++) begin
      step(); cw($sformatf("t2_a_enum%0d", i), K_ENUM, 0, (i == 1 || i == 6), 8'h11);
    end
    step(); cw("t2_a_done", K_DONE, 0, 0, 8'h11);
    step(); cw("t2_a_idle", K_IDLE, 0, 0, 8'h00);
    for (int i = 1; i <= 6; i++) begin
      step(); cw($sformatf("t2_b_enum%0d", i), K_ENUM, 1, (i == 1 || i == 6), 8'h22);
    end
    step(); cw("t2_b_done", K_DONE, 1, 0, 8'h22);
    step(); cw("t2_b_idle", K_IDLE, 0, 0, 8'h00);
    step(); cw("t2_c_enum1", K_ENUM, 0, 1, 8'h11);
    req0 = 0; req1 = 0;
    repeat (5) step();
    cw("t2_c_enum6", K_ENUM, 0, 1, 8'h11);
    step(); cw("t2_c_done", K_DONE, 0, 0, 8'h11);
    step(); cw("t2_c_idle", K_IDLE, 0, 0, 8'h00);

    // 3: count with s_is_zero high during count cycle 3 only
    req0 = 1; cmd0 = 2'd2; x0 = 8'h3C;
    for (int c = 1; c <= 8; c++) begin
      step();
      cw($sformatf("t3_cnt%0d", c), (c == 4) ? K_WRAP : K_RUN, 0, 0, 8'h3C);
      req0 = 0;
      s_is_zero = (c == 3);
    end
    step(); cw("t3_done", K_DONE, 0, 0, 8'h3C);
    step(); cw("t3_idle", K_IDLE, 0, 0, 8'h00);

    // 4: cmd 0 goes straight to DONE
    req1 = 1; cmd1 = 2'd0; x1 = 8'h33;
    step(); cw("t4_done", K_DONE, 1, 0, 8'h33); req1 = 0;
    step(); cw("t4_idle", K_IDLE, 0, 0, 8'h00);

    // 5: reset during enumerate cycle 3 aborts without done
    req0 = 1; req1 = 1; cmd0 = 2'd1; cmd1 = 2'd1; x0 = 8'h44; x1 = 8'h55;
    step(); cw("t5_enum1", K_ENUM, 0, 1, 8'h44);
    step(); step(); cw("t5_enum3", K_ENUM, 0, 0, 8'h44);
    rst = 1'b1; #1;
    cw("t5_async_rst", K_IDLE, 0, 0, 8'h00);
    step(); cw("t5_in_rst", K_IDLE, 0, 0, 8'h00);
    rst = 1'b0;
    step(); cw("t5_regrant", K_ENUM, 0, 1, 8'h44);
    req0 = 0; req1 = 0;
    repeat (5) step();
    step(); cw("t5_done", K_DONE, 0, 0, 8'h44);
    step(); cw("t5_idle", K_IDLE, 0, 0, 8'h00);

    // 6: request and inputs change after the latch edge are ignored
    req0 = 1; cmd0 = 2'd3; x0 = 8'h77;
    step(); cw("t6_load", K_LOAD, 0, 0, 8'h77);
    req0 = 0; cmd0 = 2'd2; x0 = 8'hFF;
    step(); cw("t6_step", K_STEP, 0, 0, 8'h77);
    step(); cw("t6_done", K_DONE, 0, 0, 8'h77);
    step(); cw("t6_idle", K_IDLE, 0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
